// File: rtl/tmds_channel_decoder_if.sv
// Link between a TMDS deserializer lane and its channel decoder.
// The deserializer side drives the word stream and receives bitslip requests.
interface tmds_channel_decoder_if;
    logic [9:0] tmds_in;
    logic       in_valid;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de_out;
    logic       valid_out;
    logic       bitslip;
    logic       aligned;

    modport master (
        output tmds_in, in_valid,
        input  data_out, ctrl_out, de_out, valid_out, bitslip, aligned
    );

    modport slave (
        input  tmds_in, in_valid,
        output data_out, ctrl_out, de_out, valid_out, bitslip, aligned
    );
endinterface

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel: decodes 10-bit words into video bytes or control tokens
// and hunts for the word boundary by watching for runs of control tokens.
module tmds_channel_decoder #(
    parameter int TIMEOUT   = 4096,
    parameter int CTRL_RUN  = 8,
    parameter int SLIP_WAIT = 16
) (
    input  logic                   clk_pixel,
    input  logic                   resetn,
    tmds_channel_decoder_if.slave  bus
);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {SEARCH, SLIP, LOCKED} state_t;

    state_t            state, state_next;
    logic [IDLE_W-1:0] idle_cnt, idle_next;
    logic [RUN_W-1:0]  run_cnt, run_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              bitslip_next;
    logic              is_token;
    logic [1:0]        token_ctrl;
    logic [7:0]        d;
    logic [7:0]        data_dec;

    always_comb begin
        is_token   = 1'b1;
        token_ctrl = 2'b00;
        case (bus.tmds_in)
            10'b1101010100: token_ctrl = 2'b00;
            10'b0010101011: token_ctrl = 2'b01;
            10'b0101010100: token_ctrl = 2'b10;
            10'b1010101011: token_ctrl = 2'b11;
            default:        is_token   = 1'b0;
        endcase
        d = bus.tmds_in[9] ? ~bus.tmds_in[7:0] : bus.tmds_in[7:0];
        data_dec[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data_dec[i] = bus.tmds_in[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

    // Counters update first; the state decision then sees the post-word counts,
    // so lock is checked ahead of timeout.
    always_comb begin
        state_next   = state;
        idle_next    = idle_cnt;
        run_next     = run_cnt;
        wait_next    = wait_cnt;
        bitslip_next = 1'b0;
        if (bus.in_valid) begin
            if (is_token) begin
                idle_next = '0;
                if (run_cnt != RUN_W'(CTRL_RUN)) run_next = run_cnt + 1'b1;
            end else begin
                run_next = '0;
                if (idle_cnt != IDLE_W'(TIMEOUT)) idle_next = idle_cnt + 1'b1;
            end
            case (state)
                SEARCH: begin
                    if (run_next == RUN_W'(CTRL_RUN)) begin
                        state_next = LOCKED;
                    end else if (idle_next == IDLE_W'(TIMEOUT)) begin
                        bitslip_next = 1'b1;
                        idle_next    = '0;
                        run_next     = '0;
                        wait_next    = '0;
                        state_next   = SLIP;
                    end
                end
                SLIP: begin
                    idle_next = '0;
                    run_next  = '0;
                    if (wait_cnt == WAIT_W'(SLIP_WAIT - 1)) begin
                        wait_next  = '0;
                        state_next = SEARCH;
                    end else begin
                        wait_next = wait_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (idle_next == IDLE_W'(TIMEOUT)) begin
                        idle_next  = '0;
                        run_next   = '0;
                        state_next = SEARCH;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            state         <= SEARCH;
            idle_cnt      <= '0;
            run_cnt       <= '0;
            wait_cnt      <= '0;
            bus.data_out  <= '0;
            bus.ctrl_out  <= '0;
            bus.de_out    <= 1'b0;
            bus.valid_out <= 1'b0;
            bus.bitslip   <= 1'b0;
            bus.aligned   <= 1'b0;
        end else begin
            state         <= state_next;
            idle_cnt      <= idle_next;
            run_cnt       <= run_next;
            wait_cnt      <= wait_next;
            bus.valid_out <= bus.in_valid;
            bus.bitslip   <= bitslip_next;
            bus.aligned   <= (state_next == LOCKED);
            if (bus.in_valid) begin
                if (is_token) begin
                    bus.ctrl_out <= token_ctrl;
                    bus.de_out   <= 1'b0;
                end else begin
                    bus.data_out <= data_dec;
                    bus.de_out   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: decode results flow through a
// scoreboard queue, alignment and bitslip behaviour are checked per phase.
module tb_tmds_channel_decoder;
    localparam int TIMEOUT   = 4096;
    localparam int CTRL_RUN  = 8;
    localparam int SLIP_WAIT = 16;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de;
    } exp_t;

    logic clk_pixel = 1'b0;
    logic resetn    = 1'b1;

    tmds_channel_decoder_if bus ();

    tmds_channel_decoder #(
        .TIMEOUT   (TIMEOUT),
        .CTRL_RUN  (CTRL_RUN),
        .SLIP_WAIT (SLIP_WAIT)
    ) dut (
        .clk_pixel (clk_pixel),
        .resetn    (resetn),
        .bus       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    logic [9:0] tokens [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    exp_t       sb [$];
    logic [7:0] hold_data = '0;
    logic [1:0] hold_ctrl = '0;
    logic       hold_de   = 1'b0;
    int         checks      = 0;
    int         failures    = 0;
    int         step_no     = 0;
    int         pulses      = 0;
    int         last_pulse  = -1;
    int         expect_step = 0;
    logic       aligned_ok;

    // Reference DVI encoder: transition-minimised q_m, then either polarity.
    function automatic logic [9:0] tmds_encode(input logic [7:0] b, input logic invert);
        logic [8:0] qm;
        int         ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        qm = '0;
        qm[0] = b[0];
        if (ones > 4 || (ones == 4 && b[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ b[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ b[i];
            qm[8] = 1'b1;
        end
        return invert ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm[8], qm[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"},    32'(bus.data_out),  32'd0);
        check({tag, "_ctrl"},    32'(bus.ctrl_out),  32'd0);
        check({tag, "_de"},      32'(bus.de_out),    32'd0);
        check({tag, "_valid"},   32'(bus.valid_out), 32'd0);
        check({tag, "_bitslip"}, 32'(bus.bitslip),   32'd0);
        check({tag, "_aligned"}, 32'(bus.aligned),   32'd0);
    endtask

    task automatic check_output(input logic exp_valid);
        exp_t e;
        check("valid_out", 32'(bus.valid_out), 32'(exp_valid));
        if (exp_valid) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("data_out", 32'(bus.data_out), 32'(e.data));
                check("ctrl_out", 32'(bus.ctrl_out), 32'(e.ctrl));
                check("de_out",   32'(bus.de_out),   32'(e.de));
            end
        end else begin
            check("hold_data", 32'(bus.data_out), 32'(hold_data));
            check("hold_ctrl", 32'(bus.ctrl_out), 32'(hold_ctrl));
            check("hold_de",   32'(bus.de_out),   32'(hold_de));
        end
    endtask

    task automatic apply_stimulus(input logic [9:0] word, input logic valid,
                                  input logic is_tok, input logic [7:0] exp_byte,
                                  input logic [1:0] exp_ctrl);
        exp_t e;
        @(negedge clk_pixel);
        bus.tmds_in  = word;
        bus.in_valid = valid;
        if (valid) begin
            if (is_tok) begin
                hold_ctrl = exp_ctrl;
                hold_de   = 1'b0;
            end else begin
                hold_data = exp_byte;
                hold_de   = 1'b1;
            end
            e.data = hold_data;
            e.ctrl = hold_ctrl;
            e.de   = hold_de;
            sb.push_back(e);
        end
        @(posedge clk_pixel);
        #1;
        step_no++;
        if (bus.bitslip) begin
            pulses++;
            last_pulse = step_no;
        end
        check_output(valid);
    endtask

    task automatic send_token(input int idx);
        apply_stimulus(tokens[idx], 1'b1, 1'b1, 8'h00, 2'(idx));
    endtask

    task automatic send_data(input logic [7:0] b, input logic inv);
        apply_stimulus(tmds_encode(b, inv), 1'b1, 1'b0, b, 2'b00);
    endtask

    task automatic idle_step();
        apply_stimulus(10'($urandom), 1'b0, 1'b0, 8'h00, 2'b00);
    endtask

    task automatic send_random_data(input int count, input int gap_every);
        for (int v = 1; v <= count; v++) begin
            if (gap_every > 0 && v % gap_every == 0) idle_step();
            send_data(8'($urandom), 1'($urandom));
        end
    endtask

    task automatic do_reset();
        @(negedge clk_pixel);
        resetn       = 1'b0;
        bus.in_valid = 1'b1;
        bus.tmds_in  = 10'($urandom);
        #1;
        check_zero("rst_async");
        repeat (2) begin
            @(negedge clk_pixel);
            bus.tmds_in = 10'($urandom);
            @(posedge clk_pixel);
            #1;
            check_zero("rst_hold");
        end
        sb.delete();
        hold_data = '0;
        hold_ctrl = '0;
        hold_de   = 1'b0;
        @(negedge clk_pixel);
        resetn       = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk_pixel);
        #1;
        check_zero("rst_release");
    endtask

    initial begin
        bus.tmds_in  = '0;
        bus.in_valid = 1'b0;

        // Reset, first word after release, and the four control tokens.
        do_reset();
        idle_step();
        send_data(8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) send_token(k);
        apply_stimulus(10'h100, 1'b1, 1'b0, 8'h00, 2'b00);
        send_data(8'h3C, 1'b1);
        apply_stimulus(10'h3FF, 1'b1, 1'b0, 8'h00, 2'b00);

        // Every byte in both polarities, with scattered gaps carrying junk.
        for (int b = 0; b < 256; b++) begin
            for (int inv = 0; inv < 2; inv++) begin
                if ($urandom_range(0, 7) == 0) idle_step();
                send_data(8'(b), 1'(inv));
            end
        end

        // Lock needs an unbroken run of CTRL_RUN tokens.
        do_reset();
        aligned_ok = 1'b1;
        for (int k = 0; k < CTRL_RUN - 1; k++) begin
            send_token(0);
            if (bus.aligned !== 1'b0) aligned_ok = 1'b0;
        end
        send_data(8'h11, 1'b0);
        if (bus.aligned !== 1'b0) aligned_ok = 1'b0;
        for (int k = 0; k < CTRL_RUN - 1; k++) begin
            send_token(0);
            if (bus.aligned !== 1'b0) aligned_ok = 1'b0;
        end
        check("lock_broken_run", 32'(aligned_ok), 32'd1);
        idle_step();
        check("no_lock_on_gap", 32'(bus.aligned), 32'd0);
        send_token(0);
        check("lock_after_run", 32'(bus.aligned), 32'd1);

        // Loss of lock: TIMEOUT data words drop aligned without a bitslip.
        pulses = 0;
        aligned_ok = 1'b1;
        for (int v = 1; v < TIMEOUT; v++) begin
            send_data(8'($urandom), 1'($urandom));
            if (bus.aligned !== 1'b1) aligned_ok = 1'b0;
        end
        check("locked_until_timeout", 32'(aligned_ok), 32'd1);
        send_data(8'h5A, 1'b0);
        check("unlock_at_timeout", 32'(bus.aligned), 32'd0);
        check("loss_no_bitslip", 32'(pulses), 32'd0);
        send_data(8'h5B, 1'b0);
        check("unlock_stays", 32'(bus.aligned), 32'd0);

        // Slip: pulse on the TIMEOUT-th word, SLIP_WAIT words ignored, repeat.
        do_reset();
        pulses = 0;
        last_pulse = -1;
        send_random_data(TIMEOUT, 500);
        expect_step = step_no;
        check("slip1_count", 32'(pulses), 32'd1);
        check("slip1_step", 32'(last_pulse), 32'(expect_step));
        aligned_ok = 1'b1;
        for (int k = 0; k < SLIP_WAIT; k++) begin
            if (k == 5) idle_step();
            if (k < 12) send_token(k % 4 == 0 ? 0 : 0);
            else send_data(8'($urandom), 1'b0);
            if (bus.aligned !== 1'b0) aligned_ok = 1'b0;
        end
        check("slip_ignores_tokens", 32'(aligned_ok), 32'd1);
        check("slip_wait_no_pulse", 32'(pulses), 32'd1);
        send_random_data(TIMEOUT - 1, 700);
        check("slip2_not_early", 32'(pulses), 32'd1);
        send_data(8'h77, 1'b1);
        check("slip2_count", 32'(pulses), 32'd2);
        check("slip2_step", 32'(last_pulse), 32'(step_no));

        // Reset in the middle of SLIP restarts the timeout from scratch.
        send_random_data(5, 0);
        do_reset();
        pulses = 0;
        send_random_data(TIMEOUT - 1, 900);
        check("post_reset_no_pulse", 32'(pulses), 32'd0);
        send_data(8'h99, 1'b0);
        check("post_reset_pulse", 32'(pulses), 32'd1);
        check("post_reset_step", 32'(last_pulse), 32'(step_no));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
